// File: rtl/int_to_float_module_if.sv
// Handshake bundle between the conversion sequencer and the int-to-float
// converter: level-held run enable and operand in, packed float and status out.
interface int_to_float_module_if;
   logic        Start_Sig;
   logic [31:0] Data_In;
   logic [31:0] Result;
   logic [2:0]  Done_Sig;

   modport master (
      output Start_Sig,
      output Data_In,
      input  Result,
      input  Done_Sig
   );

   modport slave (
      input  Start_Sig,
      input  Data_In,
      output Result,
      output Done_Sig
   );
endinterface

// File: rtl/int_to_float_module.sv
// Multi-cycle signed 32-bit integer to IEEE-754 single-precision converter.
// Load, zero check, iterative normalise (coarse byte steps then single bits),
// half-up rounding on the guard bit, then a one-cycle done pulse.
// Every state advances only while Start_Sig is high; otherwise all state holds.
module int_to_float_module #(
   parameter int EXP_BIAS    = 127,
   parameter int COARSE_STEP = 8
) (
   input logic                  CLK,
   input logic                  RSTn,
   int_to_float_module_if.slave bus
);

   localparam logic [7:0] EXP_PRELOAD = 8'(EXP_BIAS + 31);
   localparam logic [7:0] EXP_COARSE  = 8'(COARSE_STEP);

   typedef enum logic [2:0] {
      S_LOAD  = 3'd0,
      S_ZERO  = 3'd1,
      S_NORM  = 3'd2,
      S_ROUND = 3'd3,
      S_DONE  = 3'd4,
      S_CLEAR = 3'd5
   } state_t;

   state_t      state_r;
   logic [32:0] mag_r;       // 33 bits so the magnitude of -2^31 is exact
   logic [7:0]  exp_r;
   logic        sign_r;
   logic [31:0] result_r;
   logic        inexact_r;
   logic        zero_r;
   logic        done_r;

   logic [22:0] man_s;
   logic [7:0]  exp_rnd_s;
   logic        inexact_s;

   // Round the normalised magnitude half-up on the guard bit; a carry out of
   // an all-ones mantissa wraps it to zero and bumps the exponent instead.
   always_comb begin
      man_s     = mag_r[30:8];
      exp_rnd_s = exp_r;
      inexact_s = |mag_r[7:0];
      if (mag_r[7]) begin
         if (&mag_r[30:8]) begin
            man_s     = 23'd0;
            exp_rnd_s = exp_r + 8'd1;
         end else begin
            man_s     = mag_r[30:8] + 23'd1;
         end
      end else begin
         man_s     = mag_r[30:8];
      end
   end

   // Conversion FSM with registered outputs; advances only while Start_Sig is high.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_r   <= S_LOAD;
         mag_r     <= 33'd0;
         exp_r     <= 8'd0;
         sign_r    <= 1'b0;
         result_r  <= 32'd0;
         inexact_r <= 1'b0;
         zero_r    <= 1'b0;
         done_r    <= 1'b0;
      end else if (bus.Start_Sig) begin
         case (state_r)
            S_LOAD: begin
               if (bus.Data_In[31]) begin
                  mag_r <= {1'b0, ~bus.Data_In} + 33'd1;
               end else begin
                  mag_r <= {1'b0, bus.Data_In};
               end
               sign_r    <= bus.Data_In[31];
               exp_r     <= EXP_PRELOAD;
               zero_r    <= 1'b0;
               inexact_r <= 1'b0;
               state_r   <= S_ZERO;
            end
            S_ZERO: begin
               // A zero operand packs as +0 regardless of sign.
               if (mag_r == 33'd0) begin
                  result_r <= 32'h0000_0000;
                  zero_r   <= 1'b1;
                  state_r  <= S_DONE;
               end else begin
                  state_r  <= S_NORM;
               end
            end
            S_NORM: begin
               if (mag_r[31]) begin
                  state_r <= S_ROUND;
               end else if (mag_r[31:24] == 8'd0) begin
                  mag_r   <= mag_r << COARSE_STEP;
                  exp_r   <= exp_r - EXP_COARSE;
               end else begin
                  mag_r   <= mag_r << 1;
                  exp_r   <= exp_r - 8'd1;
               end
            end
            S_ROUND: begin
               inexact_r <= inexact_s;
               exp_r     <= exp_rnd_s;
               result_r  <= {sign_r, exp_rnd_s, man_s};
               state_r   <= S_DONE;
            end
            S_DONE: begin
               done_r  <= 1'b1;
               state_r <= S_CLEAR;
            end
            S_CLEAR: begin
               done_r  <= 1'b0;
               state_r <= S_LOAD;
            end
            default: begin
               done_r  <= 1'b0;
               state_r <= S_LOAD;
            end
         endcase
      end
   end

   assign bus.Result   = result_r;
   assign bus.Done_Sig = {inexact_r, zero_r, done_r};

endmodule

// File: tb/tb_int_to_float_module.sv
// Self-checking bench for int_to_float_module: expected results go into a
// scoreboard queue when stimulus is launched and are popped on each done pulse.
module tb_int_to_float_module;

   logic CLK;
   logic RSTn;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
   } exp_t;

   exp_t sb[$];

   int_to_float_module_if bus ();

   int_to_float_module dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference: find the leading one, round half-up on the next bit below
   // the 24 kept bits, and derive latency from the coarse/fine step count.
   function automatic exp_t model(input logic [31:0] x);
      exp_t        r;
      longint      sv;
      logic [63:0] a;
      int          p;
      int          q;
      int          steps;
      logic [23:0] sig;
      logic        guard;
      logic        inex;
      logic [7:0]  e;
      logic [24:0] sum;
      logic [22:0] man;
      sv = longint'(signed'(x));
      a  = (sv < 0) ? 64'(-sv) : 64'(sv);
      if (a == 64'd0) begin
         r.res = 32'h0000_0000;
         r.flg = 3'b011;
         r.lat = 3;
         return r;
      end
      p = 0;
      for (int i = 0; i < 32; i++) if (a[i]) p = i;
      e = 8'(127 + p);
      if (p <= 23) begin
         sig   = 24'(a << (23 - p));
         guard = 1'b0;
         inex  = 1'b0;
      end else begin
         sig   = 24'(a >> (p - 23));
         guard = a[p - 24];
         inex  = ((a & ((64'd1 << (p - 23)) - 64'd1)) != 64'd0);
      end
      sum = {1'b0, sig} + {24'd0, guard};
      if (sum[24]) begin
         e   = e + 8'd1;
         man = 23'd0;
      end else begin
         man = sum[22:0];
      end
      r.res = {x[31], e, man};
      r.flg = {inex, 1'b0, 1'b1};
      q = p;
      steps = 1;
      while (q < 24) begin
         q += 8;
         steps++;
      end
      steps += 31 - q;
      r.lat = 4 + steps;
      return r;
   endfunction

   // Launch one conversion from state 0, optionally pausing Start_Sig, and
   // return what the DUT showed on its done pulse plus the pulse width check.
   task automatic run_conv(input logic [31:0] din, input int pause_at, input int pause_len,
                           output logic [31:0] res, output logic [2:0] flg, output int lat,
                           output bit pulse_ok);
      int n;
      bit fin;
      @(negedge CLK);
      bus.Data_In   = din;
      bus.Start_Sig = 1'b1;
      n   = 0;
      fin = 1'b0;
      while (!fin) begin
         @(posedge CLK);
         #1;
         n++;
         if (n == 1) bus.Data_In = $urandom();
         if (bus.Done_Sig[0] === 1'b1) begin
            fin = 1'b1;
         end else if (n >= 200) begin
            fin = 1'b1;
         end else if (n == pause_at) begin
            bus.Start_Sig = 1'b0;
            repeat (pause_len) @(posedge CLK);
            #1;
            n += pause_len;
            bus.Start_Sig = 1'b1;
         end
      end
      res = bus.Result;
      flg = bus.Done_Sig;
      lat = n;
      @(posedge CLK);
      #1;
      pulse_ok = (bus.Done_Sig[0] === 1'b0);
      bus.Start_Sig = 1'b0;
   endtask

   task automatic test_reset();
      bus.Start_Sig = 1'b0;
      bus.Data_In   = 32'h1234_5678;
      RSTn = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      n_checks++;
      if (bus.Result !== 32'd0) $display("FAIL reset_result: got %h want %h", bus.Result, 32'd0);
      else n_pass++;
      n_checks++;
      if (bus.Done_Sig !== 3'b000) $display("FAIL reset_done: got %b want %b", bus.Done_Sig, 3'b000);
      else n_pass++;
      @(negedge CLK);
      RSTn = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      n_checks++;
      if (bus.Done_Sig !== 3'b000) $display("FAIL idle_hold: got %b want %b", bus.Done_Sig, 3'b000);
      else n_pass++;
   endtask

   task automatic test_table();
      logic [31:0] din [6];
      logic [31:0] eres [6];
      logic [2:0]  eflg [6];
      int          elat [6];
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
      bit          pok;
      exp_t        e;
      din  = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'd16777217};
      eres = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'hCF00_0000, 32'h4F00_0000, 32'h4B80_0001};
      eflg = '{3'b001, 3'b001, 3'b011, 3'b001, 3'b101, 3'b101};
      elat = '{15, 15, 3, 5, 6, 12};
      for (int i = 0; i < 6; i++) begin
         e.res = eres[i];
         e.flg = eflg[i];
         e.lat = elat[i];
         sb.push_back(e);
         run_conv(din[i], 0, 0, res, flg, lat, pok);
         e = sb.pop_front();
         n_checks++;
         if (res !== e.res) $display("FAIL table_result[%0d]: got %h want %h", i, res, e.res);
         else n_pass++;
         n_checks++;
         if (flg !== e.flg) $display("FAIL table_flags[%0d]: got %b want %b", i, flg, e.flg);
         else n_pass++;
         n_checks++;
         if (lat != e.lat) $display("FAIL table_latency[%0d]: got %0d want %0d", i, lat, e.lat);
         else n_pass++;
         n_checks++;
         if (!pok) $display("FAIL table_pulse[%0d]: got done high for 2 cycles want 1", i);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [31:0] x;
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
      bit          pok;
      exp_t        e;
      for (int i = 0; i < 10; i++) begin
         x = $urandom() >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) x = -x;
         sb.push_back(model(x));
         run_conv(x, 0, 0, res, flg, lat, pok);
         e = sb.pop_front();
         n_checks++;
         if (res !== e.res) $display("FAIL rand_result[%h]: got %h want %h", x, res, e.res);
         else n_pass++;
         n_checks++;
         if (flg !== e.flg) $display("FAIL rand_flags[%h]: got %b want %b", x, flg, e.flg);
         else n_pass++;
         n_checks++;
         if (lat != e.lat) $display("FAIL rand_latency[%h]: got %0d want %0d", x, lat, e.lat);
         else n_pass++;
      end
   endtask

   task automatic test_pause();
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
      bit          pok;
      exp_t        e;
      e.res = 32'h3F80_0000;
      e.flg = 3'b001;
      e.lat = 20;
      sb.push_back(e);
      run_conv(32'h0000_0001, 5, 5, res, flg, lat, pok);
      e = sb.pop_front();
      n_checks++;
      if (res !== e.res) $display("FAIL pause_result: got %h want %h", res, e.res);
      else n_pass++;
      n_checks++;
      if (lat != e.lat) $display("FAIL pause_latency: got %0d want %0d", lat, e.lat);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
      bit          pok;
      exp_t        e;
      @(negedge CLK);
      bus.Data_In   = 32'h0000_0001;
      bus.Start_Sig = 1'b1;
      repeat (6) @(posedge CLK);
      #1;
      RSTn = 1'b0;
      #1;
      n_checks++;
      if (bus.Result !== 32'd0) $display("FAIL midreset_result: got %h want %h", bus.Result, 32'd0);
      else n_pass++;
      n_checks++;
      if (bus.Done_Sig !== 3'b000) $display("FAIL midreset_done: got %b want %b", bus.Done_Sig, 3'b000);
      else n_pass++;
      bus.Start_Sig = 1'b0;
      @(negedge CLK);
      RSTn = 1'b1;
      e.res = 32'h3F80_0000;
      e.flg = 3'b001;
      e.lat = 15;
      sb.push_back(e);
      run_conv(32'h0000_0001, 0, 0, res, flg, lat, pok);
      e = sb.pop_front();
      n_checks++;
      if (res !== e.res) $display("FAIL restart_result: got %h want %h", res, e.res);
      else n_pass++;
      n_checks++;
      if (lat != e.lat) $display("FAIL restart_latency: got %0d want %0d", lat, e.lat);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [4];
      exp_t        e;
      int          n;
      bit          got;
      vals = '{32'h0000_0003, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0123_4567};
      for (int k = 0; k < 4; k++) sb.push_back(model(vals[k]));
      @(negedge CLK);
      bus.Data_In   = vals[0];
      bus.Start_Sig = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n   = 0;
         got = 1'b0;
         while (!got && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
            if (n == 1 && k < 3) bus.Data_In = vals[k + 1];
            if (bus.Done_Sig[0] === 1'b1) got = 1'b1;
         end
         e = sb.pop_front();
         n_checks++;
         if (bus.Result !== e.res) $display("FAIL b2b_result[%0d]: got %h want %h", k, bus.Result, e.res);
         else n_pass++;
         n_checks++;
         if (bus.Done_Sig !== e.flg) $display("FAIL b2b_flags[%0d]: got %b want %b", k, bus.Done_Sig, e.flg);
         else n_pass++;
         n_checks++;
         if (n != e.lat) $display("FAIL b2b_latency[%0d]: got %0d want %0d", k, n, e.lat);
         else n_pass++;
         @(posedge CLK);
         #1;
         n_checks++;
         if (bus.Done_Sig[0] !== 1'b0) $display("FAIL b2b_pulse[%0d]: got %b want %b", k, bus.Done_Sig[0], 1'b0);
         else n_pass++;
      end
      bus.Start_Sig = 1'b0;
   endtask

   // Run every scenario in order, then print the summary.
   initial begin
      bus.Start_Sig = 1'b0;
      bus.Data_In   = 32'd0;
      RSTn          = 1'b0;
      test_reset();
      test_table();
      test_random();
      test_pause();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
